// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// The divide datapath is present only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_t;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_hilo_unit_iter_step.sv
// One combinational iteration: shift-add multiply or restoring shift-subtract divide.
// The divide path and its select port exist only when MULDIV_DIV_EN is defined.
module muldiv_iter_step #(
  parameter int unsigned WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
  input  logic             div_mode,
`endif
  input  logic [WIDTH-1:0] opnd,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0] sum;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;
`endif

  always_comb begin
    // Multiply: acc_lo holds the remaining multiplier bits, acc_hi the partial product.
    sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    nxt_hi = sum[WIDTH:1];
    nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    // Divide: the W-bit modular difference is exact whenever the subtract succeeds,
    // and with a zero divisor it simply passes the dividend bits through.
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    fits    = shifted >= {1'b0, opnd};
    diff    = shifted[WIDTH-1:0] - opnd;
    if (div_mode) begin
      nxt_hi = fits ? diff : shifted[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], fits};
    end
`endif
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Divide support is compiled in with MULDIV_DIV_EN; otherwise DIV/DIVU complete as no-ops.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  state_t             state, state_next;
  logic               accept;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   opnd, acc_hi, acc_lo, step_hi, step_lo;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               sign_a, sign_b, neg_lo;
  logic [2*WIDTH-1:0] prod;
`ifdef MULDIV_DIV_EN
  logic               is_div, neg_hi;
`endif

  always_comb begin
    sign_a = op_is_signed(op_i) & src_a_i[WIDTH-1];
    sign_b = op_is_signed(op_i) & src_b_i[WIDTH-1];
    abs_a  = sign_a ? -src_a_i : src_a_i;
    abs_b  = sign_b ? -src_b_i : src_b_i;
    prod   = {acc_hi, acc_lo};
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_next = ST_IDLE;
        if (start_i && !flush_i) begin
          case (op_i)
            OP_MULT, OP_MULTU: begin
              state_next = ST_CALC;
              accept     = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
`ifdef MULDIV_DIV_EN
              state_next = ST_CALC;
`else
              state_next = ST_DONE;
`endif
              accept     = 1'b1;
            end
            OP_MTHI, OP_MTLO: begin
              state_next = ST_DONE;
              accept     = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_CALC: begin
        if (flush_i)
          state_next = ST_IDLE;
        else if (cnt == CNT_W'(WIDTH - 1))
          state_next = ST_FIX;
      end
      ST_FIX:  state_next = flush_i ? ST_IDLE : ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_DIV_EN
    .div_mode (is_div),
`endif
    .opnd     (opnd),
    .acc_hi   (acc_hi),
    .acc_lo   (acc_lo),
    .nxt_hi   (step_hi),
    .nxt_lo   (step_lo)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= ST_IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
      cnt    <= '0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      neg_lo <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div <= 1'b0;
      neg_hi <= 1'b0;
`endif
    end else begin
      state  <= state_next;
      busy_o <= (state_next == ST_CALC) || (state_next == ST_FIX);
      done_o <= (state_next == ST_DONE);
      if (accept) begin
        cnt <= '0;
        case (op_i)
          OP_MULT, OP_MULTU: begin
            opnd   <= abs_a;
            acc_hi <= '0;
            acc_lo <= abs_b;
            neg_lo <= sign_a ^ sign_b;
`ifdef MULDIV_DIV_EN
            is_div <= 1'b0;
`endif
          end
`ifdef MULDIV_DIV_EN
          OP_DIV, OP_DIVU: begin
            opnd   <= abs_b;
            acc_hi <= '0;
            acc_lo <= abs_a;
            is_div <= 1'b1;
            // A zero divisor must leave the all-ones quotient un-negated.
            neg_lo <= (sign_a ^ sign_b) & (src_b_i != '0);
            neg_hi <= sign_a;
          end
`endif
          OP_MTHI: hi_o <= src_a_i;
          OP_MTLO: lo_o <= src_a_i;
          default: ;
        endcase
      end else if (state == ST_CALC) begin
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        cnt    <= cnt + CNT_W'(1);
      end else if (state == ST_FIX && !flush_i) begin
`ifdef MULDIV_DIV_EN
        if (is_div) begin
          lo_o <= neg_lo ? -acc_lo : acc_lo;
          hi_o <= neg_hi ? -acc_hi : acc_hi;
        end else
`endif
        begin
          {hi_o, lo_o} <= neg_lo ? -prod : prod;
        end
      end
    end
  end

endmodule

// File: doc/muldiv_hilo_unit.md
# muldiv_hilo_unit

Iterative multiply/divide unit with architectural HI/LO registers. It is the parametrised successor to the single-cycle execute-stage ALU multiply path: it adds signed and unsigned divide, a sequential shift-add multiplier, a start/busy/done handshake, pipeline flush, and a configurable operand width. It sits beside the execute-stage ALU. The pipeline stalls on `busy_o` and reads `hi_o`/`lo_o` for MFHI/MFLO.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits. The product is `2*WIDTH` bits.
- `CNT_W`, default `$clog2(WIDTH+1)`: width of the iteration counter.

Ports:
- `clock`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-low reset.
- `start_i`, in, 1: request. Sampled at a rising edge only while not busy.
- `op_i`, in, 3: operation select, one of MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- `src_a_i`, in, `WIDTH`: multiplicand, dividend, or MTHI/MTLO data.
- `src_b_i`, in, `WIDTH`: multiplier or divisor.
- `flush_i`, in, 1: abort any in-flight operation.
- `busy_o`, out, 1: operation in progress. The pipeline must stall.
- `done_o`, out, 1: one-cycle pulse. HI/LO are updated when it is high.
- `hi_o`, out, `WIDTH`: HI register.
- `lo_o`, out, `WIDTH`: LO register.

## Operation
- **Reset** (`reset`=0 at an edge): state goes to IDLE; `busy_o`=0, `done_o`=0, `hi_o`=0, `lo_o`=0, counter=0. Reset overrides everything, including an operation in progress.
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE** + `start_i`:
  - MULT/MULTU/DIV/DIVU: latch operands → CALC, counter=0.
  - Signed ops latch absolute values. The result signs are latched as follows: product and quotient sign = a[W-1]^b[W-1]; remainder sign = a[W-1].
- **MTHI/MTLO:** write `src_a_i` to HI or LO at the accepting edge → DONE. `busy_o` is never asserted.
- **CALC:** one iteration per cycle, for `WIDTH` cycles.
  - Multiply: restoring shift-add into a `2*WIDTH`-bit accumulator.
  - Divide: restoring shift-subtract, giving a quotient and a remainder.
  - When counter = `WIDTH-1`, go to FIX.
- **FIX:** apply two's-complement negation for signed ops only. Unsigned ops are never negated. Write HI and LO → DONE.
  - Multiply: HI = product[2W-1:W], LO = product[W-1:0].
  - Divide: LO = quotient, HI = remainder.
- **DONE:** `done_o`=1 for exactly one cycle, `busy_o`=0. A `start_i` in DONE is accepted exactly as in IDLE. Otherwise → IDLE.
- **Divide by zero:** takes the full latency. LO = all ones, HI = dividend (unsigned view of `src_a_i`).
- **Signed overflow** (most-negative ÷ -1): LO = most-negative, HI = 0. This falls out naturally from the absolute-value datapath.
- **`start_i` while `busy_o`=1:** ignored. No queuing.
- **`flush_i`:**
  - In CALC or FIX: return to IDLE at the next edge. HI/LO are unchanged and no `done_o` is produced.
  - In the same cycle as `start_i`: flush wins and the start is dropped.
  - In DONE: has no effect, because HI/LO are already written.
- Undefined `op_i` codes: ignored. The unit stays in IDLE.

## Timing
- `start_i` accepted at edge k:
  - `busy_o` is high from edge k through edge k+WIDTH+1.
  - `done_o` and the new HI/LO are visible after edge k+WIDTH+1.
  - Latency is therefore WIDTH+2 cycles (34 for WIDTH=32).
- MTHI/MTLO: the register is updated after edge k, and `done_o` is high in the cycle after edge k.
- `busy_o` and `done_o` are never high together.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `MULDIV_DIV_EN` defined: DIV and DIVU are implemented as described above.
- `MULDIV_DIV_EN` undefined: the divide datapath is removed. DIV and DIVU are accepted with no busy phase, go directly to DONE, produce a one-cycle `done_o`, and leave HI/LO unchanged.

## Structure
- Package `muldiv_pkg` holds:
  - the `op_i` encodings: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5;
  - the state enum;
  - the default width constant.
- One sub-module, `muldiv_iter_step`: combinational single-iteration datapath (shift-add or shift-subtract). It is instantiated once and the top level holds the registers.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 → after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA; `done_o` high one cycle; `busy_o` high for cycles 1–33.
- MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV 0xFFFFFFF9 (-7) ÷ 0x00000002 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 ÷ 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 0x00000007 ÷ 0 → LO=0xFFFFFFFF, HI=0x00000007 after 34 cycles.
- MTHI 0x12345678, then MULT with `flush_i` at cycle 10 → HI stays 0x12345678, no `done_o`. A `start_i` asserted during busy before the flush is ignored.
- `reset`=0 at cycle 5 of a DIVU → next cycle `busy_o`=0, `done_o`=0, HI=LO=0; a new MULT completes normally.
